mc_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core datapath. It replaces the single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine and holds the instruction register. It drives the register-file addresses, the ALU function, the datapath mux selects and one-cycle write strobes for the PC, register file and data memory. It sits between the instruction memory output and the existing pc, register_file, alu, DataMemory and mux blocks.

---
 rtl/mc_control_fsm_if.sv | 46 ++++
 rtl/mc_control_fsm.sv | 174 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The perf-counter signals exist only when MC_CTRL_PERF_EN is defined.
interface mc_control_fsm_if;
    logic [31:0] instr;
    logic        stall;
    logic        ir_write;
    logic        pc_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_func3;
    logic        alu_subsra;
    logic        rf_wen;
    logic        dm_wen;
    logic [2:0]  dm_ctrl;
    logic        sel_sum_alu;
    logic        sel_pc_reg1;
    logic        sel_imm_reg2;
    logic [1:0]  sel_wb;
    logic        illegal;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    modport slave (
        input  instr, stall,
        output ir_write, pc_write, rs1, rs2, rd, alu_func3, alu_subsra,
               rf_wen, dm_wen, dm_ctrl, sel_sum_alu, sel_pc_reg1,
               sel_imm_reg2, sel_wb, illegal, state
`ifdef MC_CTRL_PERF_EN
        , output cycle_cnt, instret_cnt
`endif
    );

    modport master (
        output instr, stall,
        input  ir_write, pc_write, rs1, rs2, rd, alu_func3, alu_subsra,
               rf_wen, dm_wen, dm_ctrl, sel_sum_alu, sel_pc_reg1,
               sel_imm_reg2, sel_wb, illegal, state
`ifdef MC_CTRL_PERF_EN
        , input cycle_cnt, instret_cnt
`endif
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Optional cycle/instret counters are enabled with MC_CTRL_PERF_EN.
module mc_control_fsm (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.slave   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef struct packed {
        logic       sel_pc_reg1;
        logic       sel_imm_reg2;
        logic [2:0] alu_func3;
        logic       alu_subsra;
        logic [1:0] sel_wb;
        logic       sel_sum_alu;
    } ctl_t;

    localparam logic [31:0] IR_RESET  = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    // Selects depend only on the instruction class, so they read the same
    // from DECODE through the final state of the instruction.
    function automatic ctl_t decode_ctl(input logic [6:0] op,
                                        input logic [2:0] f3,
                                        input logic       b30);
        ctl_t c;
        c.sel_pc_reg1  = 1'b1;
        c.sel_imm_reg2 = 1'b1;
        c.alu_func3    = 3'b000;
        c.alu_subsra   = 1'b0;
        c.sel_wb       = 2'b01;
        c.sel_sum_alu  = 1'b0;
        case (op)
            OP_R: begin
                c.sel_imm_reg2 = 1'b0;
                c.alu_func3    = f3;
                c.alu_subsra   = b30;
            end
            OP_I: begin
                c.alu_func3  = f3;
                c.alu_subsra = (f3 == 3'b101) ? b30 : 1'b0;
            end
            OP_LOAD, OP_STORE: c.sel_wb = 2'b00;
            OP_JAL: begin
                c.sel_pc_reg1 = 1'b0;
                c.sel_wb      = 2'b10;
                c.sel_sum_alu = 1'b1;
            end
            OP_JALR: begin
                c.sel_wb      = 2'b10;
                c.sel_sum_alu = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    ctl_t        ctl_q;
    logic        ir_write_q, pc_write_q, rf_wen_q, dm_wen_q;
    logic        strobe_en;
    logic        unused_ir_bits;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        if (state_q != S_TRAP && !bus.stall) begin
            case (state_q)
                S_FETCH: begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (is_legal(ir_q[6:0])) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                end
                S_EXEC:  state_d = (ir_q[6:0] == OP_LOAD || ir_q[6:0] == OP_STORE) ? S_MEM : S_WB;
                S_MEM:   state_d = (ir_q[6:0] == OP_LOAD) ? S_WB : S_FETCH;
                S_WB:    state_d = S_FETCH;
                default: state_d = S_TRAP;
            endcase
        end
    end

    // Strobe flags are registered from the next state; stall and reset only
    // gate them at the output so a held state re-fires its strobe afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            ir_q       <= IR_RESET;
            illegal_q  <= 1'b0;
            ctl_q      <= decode_ctl(IR_RESET[6:0], IR_RESET[14:12], IR_RESET[30]);
            ir_write_q <= 1'b1;
            pc_write_q <= 1'b0;
            rf_wen_q   <= 1'b0;
            dm_wen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            illegal_q  <= illegal_d;
            ctl_q      <= decode_ctl(ir_d[6:0], ir_d[14:12], ir_d[30]);
            ir_write_q <= (state_d == S_FETCH);
            pc_write_q <= (state_d == S_WB) ||
                          (state_d == S_MEM && ir_d[6:0] == OP_STORE);
            rf_wen_q   <= (state_d == S_WB);
            dm_wen_q   <= (state_d == S_MEM && ir_d[6:0] == OP_STORE);
        end
    end

    assign strobe_en = reset & ~bus.stall;

    assign bus.ir_write     = ir_write_q & strobe_en;
    assign bus.pc_write     = pc_write_q & strobe_en;
    assign bus.rf_wen       = rf_wen_q & strobe_en;
    assign bus.dm_wen       = dm_wen_q & strobe_en;
    assign bus.rs1          = ir_q[19:15];
    assign bus.rs2          = ir_q[24:20];
    assign bus.rd           = ir_q[11:7];
    assign bus.dm_ctrl      = ir_q[14:12];
    assign bus.alu_func3    = ctl_q.alu_func3;
    assign bus.alu_subsra   = ctl_q.alu_subsra;
    assign bus.sel_sum_alu  = ctl_q.sel_sum_alu;
    assign bus.sel_pc_reg1  = ctl_q.sel_pc_reg1;
    assign bus.sel_imm_reg2 = ctl_q.sel_imm_reg2;
    assign bus.sel_wb       = ctl_q.sel_wb;
    assign bus.illegal      = illegal_q;
    assign bus.state        = state_q;

    assign unused_ir_bits = ^{ir_q[31], ir_q[29:25]};

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (bus.pc_write)
                instret_cnt_q <= instret_cnt_q + 32'd1;
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm plus hand-written
// sequences for stall, mid-instruction reset and the illegal-opcode trap.
module tb_mc_control_fsm;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   retired;

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          lat;
        logic [2:0]  last_st;
        logic        rf;
        logic        dm;
        logic        pc_reg1;
        logic        imm_reg2;
        logic [2:0]  f3;
        logic        subsra;
        logic [1:0]  wb;
        logic        chk_wb;
        logic        sum_alu;
        logic [2:0]  dmc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {bus.ir_write, bus.pc_write, bus.rf_wen, bus.dm_wen};
    endfunction

    function automatic logic [24:0] sels();
        return {bus.sel_pc_reg1, bus.sel_imm_reg2, bus.alu_func3, bus.alu_subsra,
                bus.sel_sum_alu, bus.dm_ctrl, bus.rd, bus.rs1, bus.rs2};
    endfunction

    // Entered at a falling edge with the FSM in FETCH; leaves at the falling
    // edge of the next FETCH.
    task automatic run_vec(input vec_t v);
        logic [2:0] exp_st;
        logic [3:0] exp_sb;
        for (int c = 0; c < v.lat; c++) begin
            if (c == 0) bus.instr = v.instr;
            #1;
            if (c < 3)            exp_st = 3'(c);
            else if (c == v.lat - 1) exp_st = v.last_st;
            else                  exp_st = 3'd3;
            if (c == 0)              exp_sb = 4'b1000;
            else if (c == v.lat - 1) exp_sb = {1'b0, 1'b1, v.rf, v.dm};
            else                     exp_sb = 4'b0000;
            chk("state", 32'(bus.state), 32'(exp_st));
            chk("strobes", 32'(strobes()), 32'(exp_sb));
            if (c >= 2) begin
                chk("selects", 32'(sels()),
                    32'({v.pc_reg1, v.imm_reg2, v.f3, v.subsra, v.sum_alu,
                         v.dmc, v.rd, v.rs1, v.rs2}));
                if (v.chk_wb) chk("sel_wb", 32'(bus.sel_wb), 32'(v.wb));
            end
            @(negedge clk);
        end
        retired++;
        $display("instr %h: %0d cycles applied", v.instr, v.lat);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        retired   = 0;
        reset     = 1'b0;
        bus.stall = 1'b0;
        bus.instr = 32'h0;

        //            instr        lat last rf dm  p1 i2 f3     sub wb     cw sum dmc    rd  rs1 rs2
        vecs[0] = '{32'h00500093, 4, 3'd4, 1, 0, 1, 1, 3'b000, 0, 2'b01, 1, 0, 3'b000, 1,  0, 5};
        vecs[1] = '{32'h402081B3, 4, 3'd4, 1, 0, 1, 0, 3'b000, 1, 2'b01, 1, 0, 3'b000, 3,  1, 2};
        vecs[2] = '{32'h4010D213, 4, 3'd4, 1, 0, 1, 1, 3'b101, 1, 2'b01, 1, 0, 3'b101, 4,  1, 1};
        vecs[3] = '{32'h00802283, 5, 3'd4, 1, 0, 1, 1, 3'b000, 0, 2'b00, 1, 0, 3'b010, 5,  0, 8};
        vecs[4] = '{32'h00502623, 4, 3'd3, 0, 1, 1, 1, 3'b000, 0, 2'b00, 0, 0, 3'b010, 12, 0, 5};
        vecs[5] = '{32'h010000EF, 4, 3'd4, 1, 0, 0, 1, 3'b000, 0, 2'b10, 1, 1, 3'b000, 1,  0, 16};
        vecs[6] = '{32'h00408167, 4, 3'd4, 1, 0, 1, 1, 3'b000, 0, 2'b10, 1, 1, 3'b000, 2,  1, 4};
        vecs[7] = '{32'h00208333, 4, 3'd4, 1, 0, 1, 0, 3'b000, 0, 2'b01, 1, 0, 3'b000, 6,  1, 2};
        vecs[8] = '{32'hC000C393, 4, 3'd4, 1, 0, 1, 1, 3'b100, 0, 2'b01, 1, 0, 3'b100, 7,  1, 0};

        // Reset state: FETCH, strobes forced low, selects decode from 0x13.
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_selects", 32'(sels()), 32'({1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0}));
        chk("rst_sel_wb", 32'(bus.sel_wb), 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Stall for three cycles in EXEC of add x6,x1,x2.
        bus.instr = 32'h00208333;
        #1 chk("stl_fetch", 32'(strobes()), 32'b1000);
        @(negedge clk);
        #1 chk("stl_decode", 32'(bus.state), 32'd1);
        @(negedge clk);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stl_exec_state", 32'(bus.state), 32'd2);
            chk("stl_exec_strobes", 32'(strobes()), 32'd0);
            chk("stl_exec_sel", 32'(sels()), 32'({1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 5'd6, 5'd1, 5'd2}));
            @(negedge clk);
        end
        bus.stall = 1'b0;
        #1 chk("stl_resume_state", 32'(bus.state), 32'd2);
        @(negedge clk);
        #1;
        chk("stl_wb_state", 32'(bus.state), 32'd4);
        chk("stl_wb_strobes", 32'(strobes()), 32'b0110);
        // Stall raised inside WB must mask the strobes in that very cycle.
        bus.stall = 1'b1;
        #1 chk("stl_wb_gated", 32'(strobes()), 32'd0);
        @(negedge clk);
        #1 chk("stl_wb_hold", 32'(bus.state), 32'd4);
        bus.stall = 1'b0;
        #1 chk("stl_wb_refire", 32'(strobes()), 32'b0110);
        @(negedge clk);
        retired++;
        $display("instr 00208333: stalled in EXEC and WB");

        // Reset during MEM of lw: no write strobe, back to FETCH with IR=0x13.
        bus.instr = 32'h00802283;
        repeat (3) @(negedge clk);
        #1 chk("rstm_mem_state", 32'(bus.state), 32'd3);
        reset = 1'b0;
        #1;
        chk("rstm_state", 32'(bus.state), 32'd0);
        chk("rstm_strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        #1;
        chk("rstm_hold_strobes", 32'(strobes()), 32'd0);
        chk("rstm_ir", 32'(sels()), 32'({1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0}));
        reset   = 1'b1;
        retired = 0;
        $display("instr 00802283: reset asserted in MEM");
        run_vec(vecs[0]);

        // Unsupported opcode: TRAP is sticky and silent, stall irrelevant.
        bus.instr = 32'h0000007F;
        #1 chk("trap_fetch", 32'(bus.state), 32'd0);
        @(negedge clk);
        #1;
        chk("trap_decode", 32'(bus.state), 32'd1);
        chk("trap_pre_illegal", 32'(bus.illegal), 32'd0);
        bus.instr = 32'h00500093;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            bus.stall = (k % 3 == 1);
            #1;
            chk("trap_state", 32'(bus.state), 32'd7);
            chk("trap_illegal", 32'(bus.illegal), 32'd1);
            chk("trap_strobes", 32'(strobes()), 32'd0);
            @(negedge clk);
        end
        bus.stall = 1'b0;
        $display("instr 0000007f: trapped for 20 cycles");

`ifdef MC_CTRL_PERF_EN
        chk("instret_cnt", bus.instret_cnt, 32'(retired));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
